// File: rtl/tone_period_meter_if.sv
// Bus between a tone period meter and its consumer: square-wave input plus
// measured period, update strobe and lock/silence status.
interface tone_period_meter_if #(
   parameter int unsigned WIDTH = 22
);
   logic             sound_in;
   logic [WIDTH-1:0] period;
   logic             period_valid;
   logic             locked;
   logic             silent;

   modport master (
      output sound_in,
      input  period,
      input  period_valid,
      input  locked,
      input  silent
   );

   modport slave (
      input  sound_in,
      output period,
      output period_valid,
      output locked,
      output silent
   );
endinterface

// File: rtl/tone_period_meter.sv
// Measures the clock count between edges of an asynchronous square wave and
// reports it as the tone generator's half-period N, with lock and silence flags.
module tone_period_meter #(
   parameter int unsigned      WIDTH    = 22,
   parameter logic [WIDTH-1:0] TIMEOUT  = 22'h3FFFFF,
   parameter int unsigned      TOL      = 2,
   parameter int unsigned      LOCK_CNT = 4
) (
   input logic                clk,
   input logic                rst,
   tone_period_meter_if.slave bus
);
   localparam int unsigned      MW    = $clog2(LOCK_CNT + 1);
   localparam logic [WIDTH:0]   TOL_W = (WIDTH + 1)'(TOL);
   localparam logic [MW-1:0]    LOCK_W = MW'(LOCK_CNT);

   typedef enum logic [1:0] {IDLE, ARMED, TRACK, LOCKED} state_t;

   state_t           state_q, state_d;
   logic             s1_q, s2_q, sprev_q;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic [MW-1:0]    match_q, match_d;

   logic             edge_w;
   logic             timeout_w;
   logic [WIDTH:0]   diff_w;
   logic             within_w;
   logic [MW-1:0]    match_inc_w;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         sprev_q  <= 1'b0;
         cnt_q    <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         match_q  <= '0;
         state_q  <= IDLE;
      end else begin
         s1_q     <= bus.sound_in;
         s2_q     <= s1_q;
         sprev_q  <= s2_q;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         match_q  <= match_d;
         state_q  <= state_d;
      end
   end

   assign edge_w    = s2_q ^ sprev_q;
   assign timeout_w = (cnt_q == TIMEOUT) && !edge_w;

   // Extra bit keeps the absolute difference free of wrap-around.
   assign diff_w = ({1'b0, cnt_q} >= {1'b0, period_q}) ?
                   ({1'b0, cnt_q} - {1'b0, period_q}) :
                   ({1'b0, period_q} - {1'b0, cnt_q});
   assign within_w    = (diff_w <= TOL_W);
   assign match_inc_w = (match_q == LOCK_W) ? match_q : (match_q + MW'(1));

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      valid_d  = 1'b0;
      match_d  = match_q;
      if (edge_w)
         cnt_d = '0;
      else if (cnt_q == TIMEOUT)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + WIDTH'(1);

      if (edge_w) begin
         case (state_q)
            IDLE: state_d = ARMED;
            ARMED: begin
               state_d  = TRACK;
               period_d = cnt_q;
               valid_d  = 1'b1;
               match_d  = '0;
            end
            TRACK, LOCKED: begin
               period_d = cnt_q;
               valid_d  = 1'b1;
               if (within_w) begin
                  match_d = match_inc_w;
                  if (match_inc_w == LOCK_W)
                     state_d = LOCKED;
               end else begin
                  match_d = '0;
                  state_d = TRACK;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (timeout_w && (state_q != IDLE)) begin
         state_d  = IDLE;
         period_d = '0;
         match_d  = '0;
      end
   end

   always_comb begin
      bus.period       = period_q;
      bus.period_valid = valid_q;
      bus.locked       = (state_q == LOCKED);
      bus.silent       = (state_q == IDLE);
   end
endmodule

// File: tb/tb_tone_period_meter.sv
// Directed bench for tone_period_meter (TIMEOUT shortened to 100) with a
// scoreboard of expected period/locked values popped on each period_valid.
module tb_tone_period_meter;
   localparam int unsigned W    = 22;
   localparam int          TOL  = 2;
   localparam int          LOCK = 4;

   typedef struct {
      int   p;
      logic lk;
   } exp_t;

   typedef enum {M_IDLE, M_ARMED, M_TRACK, M_LOCKED} mst_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   tone_period_meter_if #(.WIDTH(W)) bus ();

   tone_period_meter #(
      .WIDTH   (W),
      .TIMEOUT (22'd100),
      .TOL     (TOL),
      .LOCK_CNT(LOCK)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   int   since = 0;
   exp_t sb[$];
   mst_t m_st = M_IDLE;
   int   m_period = 0;
   int   m_match = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      since++;
      if (!rst && bus.period_valid === 1'b1) begin
         n_vec++;
         assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL spurious_valid observed period=%0d expected no pulse", bus.period);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_period", 32'(bus.period), 32'(e.p));
            chk("sb_locked", 32'(bus.locked), 32'(e.lk));
         end
      end
   endtask

   task automatic model_reset();
      m_st     = M_IDLE;
      m_period = 0;
      m_match  = 0;
   endtask

   // Interval-level behavioural model: c is the expected count at this edge.
   task automatic model_edge(input int c);
      exp_t e;
      int   d;
      case (m_st)
         M_IDLE: m_st = M_ARMED;
         M_ARMED: begin
            m_st    = M_TRACK;
            m_match = 0;
            e.p = c; e.lk = 1'b0; sb.push_back(e);
            m_period = c;
         end
         default: begin
            d = (c > m_period) ? c - m_period : m_period - c;
            if (d <= TOL) begin
               if (m_match < LOCK) m_match++;
               if (m_match == LOCK) m_st = M_LOCKED;
            end else begin
               m_match = 0;
               m_st    = M_TRACK;
            end
            e.p = c; e.lk = (m_st == M_LOCKED); sb.push_back(e);
            m_period = c;
         end
      endcase
   endtask

   task automatic edge_after(input int gap);
      while (since < gap) tick();
      bus.sound_in = ~bus.sound_in;
      model_edge(since - 1);
      since = 0;
   endtask

   task automatic first_edge_and_lock(input string tag);
      edge_after(0);
      tick(); tick();
      chk({tag, "_silent_before"}, 32'(bus.silent), 32'd1);
      tick();
      chk({tag, "_silent_after"}, 32'(bus.silent), 32'd0);
      repeat (4) edge_after(10);
      chk({tag, "_unlocked_4th"}, 32'(bus.locked), 32'd0);
      edge_after(10);
      repeat (2) tick();
      chk({tag, "_not_yet"}, 32'(bus.locked), 32'd0);
      tick();
      chk({tag, "_locked_5th"}, 32'(bus.locked), 32'd1);
      chk({tag, "_period"}, 32'(bus.period), 32'd9);
   endtask

   initial begin
      bus.sound_in = 1'b0;
      // 1: reset state and prolonged silence
      #2;
      chk("rst_silent", 32'(bus.silent), 32'd1);
      chk("rst_period", 32'(bus.period), 32'd0);
      chk("rst_valid",  32'(bus.period_valid), 32'd0);
      chk("rst_locked", 32'(bus.locked), 32'd0);
      repeat (3) tick();
      rst = 1'b0;
      repeat (1000) tick();
      chk("t1_silent", 32'(bus.silent), 32'd1);
      chk("t1_period", 32'(bus.period), 32'd0);

      // 2: N=9 generator
      first_edge_and_lock("t2");

      // 3: jitter within and beyond tolerance
      edge_after(11);
      repeat (4) tick();
      chk("t3_jit_locked", 32'(bus.locked), 32'd1);
      chk("t3_jit_period", 32'(bus.period), 32'd10);
      edge_after(15);
      repeat (4) tick();
      chk("t3_big_locked", 32'(bus.locked), 32'd0);
      chk("t3_big_period", 32'(bus.period), 32'd14);
      repeat (4) edge_after(10);
      repeat (4) tick();
      chk("t3_relock_pending", 32'(bus.locked), 32'd0);
      edge_after(10);
      repeat (4) tick();
      chk("t3_relocked", 32'(bus.locked), 32'd1);

      // 4: timeout after freezing the input
      while (since < 103) tick();
      chk("t4_pre_silent", 32'(bus.silent), 32'd0);
      chk("t4_pre_locked", 32'(bus.locked), 32'd1);
      tick();
      chk("t4_silent", 32'(bus.silent), 32'd1);
      chk("t4_locked", 32'(bus.locked), 32'd0);
      chk("t4_period", 32'(bus.period), 32'd0);
      model_reset();
      edge_after(5);
      repeat (4) tick();
      chk("t4_armed_silent", 32'(bus.silent), 32'd0);
      chk("t4_armed_period", 32'(bus.period), 32'd0);

      // 5: toggle every clock
      repeat (8) edge_after(1);
      repeat (4) tick();
      chk("t5_locked", 32'(bus.locked), 32'd1);
      chk("t5_period", 32'(bus.period), 32'd0);

      // 6: asynchronous reset while locked
      tick();
      #2 rst = 1'b1;
      #1;
      chk("t6_silent", 32'(bus.silent), 32'd1);
      chk("t6_locked", 32'(bus.locked), 32'd0);
      chk("t6_period", 32'(bus.period), 32'd0);
      chk("t6_valid",  32'(bus.period_valid), 32'd0);
      bus.sound_in = 1'b0;
      sb.delete();
      model_reset();
      repeat (3) tick();
      rst = 1'b0;
      repeat (20) tick();
      first_edge_and_lock("t6");
      repeat (4) tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
